// File: rtl/trace_canvas_pkg.sv
// ============================================================================
// Module   : trace_canvas_pkg
// Purpose  : Shared encodings and default colours for the sketch canvas engine
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_canvas_pkg;

    localparam logic [1:0] PEN_MOVE  = 2'b00;
    localparam logic [1:0] PEN_DRAW  = 2'b01;
    localparam logic [1:0] PEN_ERASE = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [11:0] C_INK_RGB = 12'h000;
    localparam logic [11:0] C_BG_RGB  = 12'hCCC;
    localparam logic [11:0] C_CUR_RGB = 12'hF00;

endpackage

`default_nettype wire

// File: rtl/trace_canvas_gen_ram.sv
// ============================================================================
// Module   : canvas_ram
// Purpose  : 1-bit simple dual-port tile bitmap, synchronous read (latency 1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module canvas_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic r_mem [DEPTH];
    logic r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/trace_canvas_gen.sv
// ============================================================================
// Module   : trace_canvas_gen
// Purpose  : Etch-A-Sketch canvas: pen cursor, tile bitmap, clear sweep, RGB render
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_canvas_gen
    import trace_canvas_pkg::*;
#(
    parameter int          TILE_W    = 8,
    parameter int          TILE_H    = 16,
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter int          WRAP      = 1,
    parameter int          BLINK_CYC = 25000000,
    parameter logic [11:0] INK_RGB   = C_INK_RGB,
    parameter logic [11:0] BG_RGB    = C_BG_RGB,
    parameter logic [11:0] CUR_RGB   = C_CUR_RGB,
    localparam int         CXW       = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int         CYW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           step_xr,
    input  logic           step_xl,
    input  logic           step_yu,
    input  logic           step_yd,
    input  logic [1:0]     pen_mode,
    input  logic           clear_req,
    input  logic           video_on,
    input  logic [9:0]     x,
    input  logic [9:0]     y,
    output logic [11:0]    rgb,
    output logic           busy,
    output logic [CXW-1:0] cur_x,
    output logic [CYW-1:0] cur_y
);

    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW_SH = $clog2(TILE_W);
    localparam int TH_SH = $clog2(TILE_H);

    localparam logic [AW-1:0]  C_LAST    = AW'(DEPTH - 1);
    localparam logic [AW-1:0]  C_COLS    = AW'(COLS);
    localparam logic [CXW-1:0] C_COL_MAX = CXW'(COLS - 1);
    localparam logic [CYW-1:0] C_ROW_MAX = CYW'(ROWS - 1);

    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_sweep, w_sweep_nxt;
    logic [CXW-1:0] r_cur_x, w_cur_x_nxt;
    logic [CYW-1:0] r_cur_y, w_cur_y_nxt;
    logic           w_we, w_wdata, w_rd_bit, w_phase;
    logic [AW-1:0]  w_waddr, w_raddr, w_pen_addr;
    logic [9:0]     w_col, w_row;
    logic           w_in_grid, w_hit;
    logic           r_s1_vo, r_s1_in_grid, r_s1_hit;
    logic [11:0]    r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                    w_sweep_nxt = '0;
                end
            end
            CLEAR: begin
                if (r_sweep == C_LAST) begin
                    w_state_nxt = IDLE;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Opposing pulses on one axis cancel; edges wrap or hold depending on WRAP.
    always_comb begin
        w_cur_x_nxt = r_cur_x;
        w_cur_y_nxt = r_cur_y;
        if (step_xr && !step_xl) begin
            w_cur_x_nxt = (r_cur_x == C_COL_MAX) ? ((WRAP != 0) ? '0 : r_cur_x) : r_cur_x + 1'b1;
        end else if (step_xl && !step_xr) begin
            w_cur_x_nxt = (r_cur_x == '0) ? ((WRAP != 0) ? C_COL_MAX : r_cur_x) : r_cur_x - 1'b1;
        end
        if (step_yd && !step_yu) begin
            w_cur_y_nxt = (r_cur_y == C_ROW_MAX) ? ((WRAP != 0) ? '0 : r_cur_y) : r_cur_y + 1'b1;
        end else if (step_yu && !step_yd) begin
            w_cur_y_nxt = (r_cur_y == '0) ? ((WRAP != 0) ? C_ROW_MAX : r_cur_y) : r_cur_y - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_x <= CXW'(COLS / 2);
            r_cur_y <= CYW'(ROWS / 2);
        end else if (r_state == IDLE) begin
            r_cur_x <= w_cur_x_nxt;
            r_cur_y <= w_cur_y_nxt;
        end
    end

    assign w_pen_addr = AW'(r_cur_y) * C_COLS + AW'(r_cur_x);

    // The sweep owns the write port; pen writes only happen while idle.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sweep;
        w_wdata = 1'b0;
        if (r_state == CLEAR) begin
            w_we = 1'b1;
        end else if (pen_mode == PEN_DRAW || pen_mode == PEN_ERASE) begin
            w_we    = 1'b1;
            w_waddr = w_pen_addr;
            w_wdata = (pen_mode == PEN_DRAW);
        end
    end

    assign w_col     = x >> TW_SH;
    assign w_row     = y >> TH_SH;
    assign w_in_grid = (w_col < 10'(COLS)) && (w_row < 10'(ROWS));
    assign w_raddr   = w_in_grid ? (AW'(w_row) * C_COLS + AW'(w_col)) : '0;
    assign w_hit     = (w_col == 10'(r_cur_x)) && (w_row == 10'(r_cur_y));

    canvas_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_raddr),
        .rdata (w_rd_bit)
    );

    generate
        if (BLINK_CYC == 0) begin : g_blink_off
            assign w_phase = 1'b1;
        end else begin : g_blink_on
            localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
            localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_CYC - 1);
            logic [BW-1:0] r_cnt;
            logic          r_phase;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_phase <= 1'b1;
                end else if (r_cnt == C_BLINK_LAST) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_phase = r_phase;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vo      <= 1'b0;
            r_s1_in_grid <= 1'b0;
            r_s1_hit     <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_s1_vo      <= video_on;
            r_s1_in_grid <= w_in_grid;
            r_s1_hit     <= w_hit;
            if (!r_s1_vo) begin
                r_rgb <= '0;
            end else if (!r_s1_in_grid) begin
                r_rgb <= BG_RGB;
            end else if (r_s1_hit && w_phase) begin
                r_rgb <= CUR_RGB;
            end else if (w_rd_bit) begin
                r_rgb <= INK_RGB;
            end else begin
                r_rgb <= BG_RGB;
            end
        end
    end

    assign rgb   = r_rgb;
    assign busy  = (r_state == CLEAR);
    assign cur_x = r_cur_x;
    assign cur_y = r_cur_y;

endmodule

`default_nettype wire

// File: tb/tb_trace_canvas_gen.sv
// ============================================================================
// Module   : tb_trace_canvas_gen
// Purpose  : Scoreboard bench for two canvas configurations driven in lockstep
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_canvas_gen;

    localparam int COLS   = 80;
    localparam int TW     = 8;
    localparam int TH     = 16;
    localparam int ROWS_A = 30;
    localparam int ROWS_B = 29;
    localparam int BLK_A  = 4;
    localparam int BLK_B  = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       xr = 1'b0, xl = 1'b0, yu = 1'b0, yd = 1'b0;
    logic [1:0] pen = 2'b00;
    logic       clr = 1'b0;
    logic       vo = 1'b0;
    logic [9:0] px = '0, py = '0;

    logic [11:0] rgb_a, rgb_b;
    logic        busy_a, busy_b;
    logic [6:0]  cx_a, cx_b;
    logic [4:0]  cy_a, cy_b;

    trace_canvas_gen #(.ROWS(ROWS_A), .WRAP(1), .BLINK_CYC(BLK_A)) dut_a (
        .clk(clk), .reset(reset), .step_xr(xr), .step_xl(xl), .step_yu(yu), .step_yd(yd),
        .pen_mode(pen), .clear_req(clr), .video_on(vo), .x(px), .y(py),
        .rgb(rgb_a), .busy(busy_a), .cur_x(cx_a), .cur_y(cy_a));

    trace_canvas_gen #(.ROWS(ROWS_B), .WRAP(0), .BLINK_CYC(BLK_B)) dut_b (
        .clk(clk), .reset(reset), .step_xr(xr), .step_xl(xl), .step_yu(yu), .step_yd(yd),
        .pen_mode(pen), .clear_req(clr), .video_on(vo), .x(px), .y(py),
        .rgb(rgb_b), .busy(busy_b), .cur_x(cx_b), .cur_y(cy_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int inst;
        int rgb;
        int busy;
        int cx;
        int cy;
    } exp_t;

    exp_t q_rgb[$];
    exp_t q_st[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: tile bitmap per instance plus cursor, clear progress and edge count.
    bit bm    [2][COLS*ROWS_A];
    bit known [2][COLS*ROWS_A];
    int mcx[2], mcy[2], msweep[2], kedge[2];
    bit mclr[2];

    function automatic int rows_of(input int i);
        return (i == 0) ? ROWS_A : ROWS_B;
    endfunction

    function automatic bit phase_after(input int i, input int k);
        int b;
        b = (i == 0) ? BLK_A : BLK_B;
        if (b == 0) return 1'b1;
        return ((k / b) % 2) == 0;
    endfunction

    function automatic int move(input int v, input bit inc, input bit dec, input int lim, input bit wrap);
        if (inc == dec) return v;
        if (wrap) return inc ? (v + 1) % lim : (v + lim - 1) % lim;
        return inc ? ((v + 1 < lim) ? v + 1 : v) : ((v > 0) ? v - 1 : v);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        q_rgb.delete();
        q_st.delete();
        for (int i = 0; i < 2; i++) begin
            mcx[i]    = COLS / 2;
            mcy[i]    = rows_of(i) / 2;
            mclr[i]   = 1'b1;
            msweep[i] = 0;
            kedge[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Apply the upcoming clock edge to the model and queue what the DUT must show.
    task automatic tick();
        int   col, row, n, a;
        bit   push;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            col  = int'(px) / TW;
            row  = int'(py) / TH;
            n    = COLS * rows_of(i);
            push = 1'b1;
            e    = '{due: cyc + 2, inst: i, rgb: 0, busy: 0, cx: 0, cy: 0};
            if (!vo) e.rgb = 0;
            else if (col >= COLS || row >= rows_of(i)) e.rgb = 'hCCC;
            else if (col == mcx[i] && row == mcy[i] && phase_after(i, kedge[i] + 1)) e.rgb = 'hF00;
            else begin
                a = row * COLS + col;
                push  = known[i][a];
                e.rgb = bm[i][a] ? 'h000 : 'hCCC;
            end
            if (push) q_rgb.push_back(e);

            if (mclr[i]) begin
                bm[i][msweep[i]]    = 1'b0;
                known[i][msweep[i]] = 1'b1;
                msweep[i]++;
                if (msweep[i] == n) mclr[i] = 1'b0;
            end else begin
                a = mcy[i] * COLS + mcx[i];
                if (pen == 2'b01 || pen == 2'b10) begin
                    bm[i][a]    = (pen == 2'b01);
                    known[i][a] = 1'b1;
                end
                mcx[i] = move(mcx[i], xr, xl, COLS, i == 0);
                mcy[i] = move(mcy[i], yd, yu, rows_of(i), i == 0);
                if (clr) begin
                    mclr[i]   = 1'b1;
                    msweep[i] = 0;
                end
            end
            kedge[i]++;
            q_st.push_back('{due: cyc + 1, inst: i, rgb: 0, busy: int'(mclr[i]), cx: mcx[i], cy: mcy[i]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_steps(input bit r, input bit l, input bit u, input bit d);
        xr = r; xl = l; yu = u; yd = d;
    endtask

    task automatic rand_steps(input int pct);
        set_steps($urandom_range(99) < pct, $urandom_range(99) < pct,
                  $urandom_range(99) < pct, $urandom_range(99) < pct);
    endtask

    task automatic rand_pixel();
        vo = ($urandom_range(7) != 0);
        case ($urandom_range(3))
            0: begin
                px = 10'(mcx[0] * TW + int'($urandom_range(TW - 1)));
                py = 10'(mcy[0] * TH + int'($urandom_range(TH - 1)));
            end
            1: begin
                px = 10'($urandom_range(1023));
                py = 10'($urandom_range(1023));
            end
            default: begin
                px = 10'($urandom_range(639));
                py = 10'($urandom_range(479));
            end
        endcase
    endtask

    task automatic chk(input string nm, input int inst, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, inst, cyc, got, exp);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        while (q_st.size() != 0 && q_st[0].due <= cyc) begin
            me = q_st.pop_front();
            if (me.due == cyc) begin
                chk("busy",  me.inst, (me.inst == 0) ? int'(busy_a) : int'(busy_b), me.busy);
                chk("cur_x", me.inst, (me.inst == 0) ? int'(cx_a)   : int'(cx_b),   me.cx);
                chk("cur_y", me.inst, (me.inst == 0) ? int'(cy_a)   : int'(cy_b),   me.cy);
            end
        end
        while (q_rgb.size() != 0 && q_rgb[0].due <= cyc) begin
            me = q_rgb.pop_front();
            if (me.due == cyc)
                chk("rgb", me.inst, (me.inst == 0) ? int'(rgb_a) : int'(rgb_b), me.rgb);
        end
    end

    initial begin
        int tc, tr;
        do_reset();
        // Post-reset sweep: steps dropped while busy, partial canvas visible.
        for (int i = 0; i < 2450; i++) begin
            rand_pixel();
            rand_steps((i < 2300) ? 30 : 0);
            tick();
        end
        // Draw while stepping right three times.
        pen = 2'b01;
        for (int j = 0; j < 3; j++) begin
            rand_pixel(); set_steps(1, 0, 0, 0); tick();
            set_steps(0, 0, 0, 0); tick();
        end
        tick();
        pen = 2'b00;
        vo  = 1'b1;
        for (int c = 40; c <= 43; c++) begin
            for (int r = 14; r <= 15; r++) begin
                px = 10'(c * TW + 3); py = 10'(r * TH + 5); tick();
            end
        end
        px = 10'd328; py = 10'd248;
        repeat (4) tick();
        // Random draw/erase/move traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_pixel(); rand_steps(15); pen = 2'($urandom_range(3)); tick();
        end
        pen = 2'b00;
        // Edge behaviour: wrap on one instance, saturate on the other.
        do_reset();
        set_steps(0, 0, 0, 0);
        for (int i = 0; i < 2400; i++) begin rand_pixel(); tick(); end
        for (int j = 0; j < 41; j++) begin rand_pixel(); set_steps(0, 1, 0, 0); tick(); end
        set_steps(0, 0, 1, 1); tick();
        for (int j = 0; j < 20; j++) begin rand_pixel(); set_steps(0, 0, 1, 0); tick(); end
        for (int j = 0; j < 3; j++) begin rand_pixel(); set_steps(1, 1, 0, 1); tick(); end
        set_steps(0, 0, 0, 0);
        // Clear sweep with steps and a second clear request mid-sweep.
        tc = mcx[0]; tr = mcy[0];
        pen = 2'b01; tick(); pen = 2'b00;
        vo = 1'b1; px = 10'(tc * TW + 1); py = 10'(tr * TH + 1);
        set_steps(1, 0, 0, 1); tick();
        set_steps(0, 0, 0, 0); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 2450; i++) begin
            rand_pixel(); rand_steps(20); clr = (i == 500); tick();
        end
        clr = 1'b0; set_steps(0, 0, 0, 0);
        vo = 1'b1; px = 10'(tc * TW + 1); py = 10'(tr * TH + 1);
        repeat (4) tick();
        // Reset part-way through a sweep restarts it from the beginning.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 1000; i++) begin rand_pixel(); rand_steps(20); tick(); end
        do_reset();
        for (int i = 0; i < 2410; i++) begin
            rand_pixel(); rand_steps((i < 2300) ? 20 : 0); tick();
        end
        set_steps(0, 0, 0, 0);
        // Display corner cases and cursor blink.
        for (int j = 0; j < 5; j++) begin rand_pixel(); vo = 1'b0; tick(); end
        vo = 1'b1; px = 10'd639; py = 10'd479;
        repeat (4) tick();
        px = 10'(mcx[0] * TW + 2); py = 10'(mcy[0] * TH + 3);
        repeat (20) tick();
        vo = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
